mult_seq: RTL and testbench

//  Parametrised iterative multiplier; successor to the fixed 16x16 combinational tile multiplier.
//  - Multiplies two WIDTH-bit operands, signed or unsigned (chosen per operation), into a 2*WIDTH product.
//  - Consumes DIGIT bits of operand B per clock, so area and latency trade off via DIGIT.
//  - Sits beside the CPU ALU as a multi-cycle unit with valid/ready handshakes on both sides.

---
 rtl/mult_seq.sv | 106 ++++++++++
 tb/tb_mult_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// Iterative WIDTH x WIDTH signed/unsigned multiplier consuming DIGIT bits of B per cycle.
// out_valid rises N=WIDTH/DIGIT cycles after accept; one operation in flight, P held until out_ready.
module mult_seq #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic [KW-1:0]    r_k;
  logic             r_sign;
  logic [PW-1:0]    r_mag_a;
  logic [WIDTH-1:0] r_mag_b;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_nxt;

  // |-2^(W-1)| wraps to 2^(W-1), which is the correct unsigned magnitude.
  assign w_abs_a = (is_signed && A[WIDTH-1]) ? -A : A;
  assign w_abs_b = (is_signed && B[WIDTH-1]) ? -B : B;

  // magA is pre-shifted by k*DIGIT and B is consumed from its low digit,
  // so each step adds magA<<(k*DIGIT) times the current digit of B.
  assign w_pp      = r_mag_a * PW'(r_mag_b[DIGIT-1:0]);
  assign w_acc_nxt = r_acc + w_pp;
  assign w_last    = (r_k == KW'(N - 1));
  assign P         = r_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_sign  <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_acc   <= '0;
      r_p     <= '0;
    end else if (w_accept) begin
      r_k     <= '0;
      r_sign  <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
      r_mag_a <= PW'(w_abs_a);
      r_mag_b <= w_abs_b;
      r_acc   <= '0;
    end else if (r_state == S_CALC) begin
      r_k     <= r_k + 1'b1;
      r_acc   <= w_acc_nxt;
      r_mag_a <= r_mag_a << DIGIT;
      r_mag_b <= r_mag_b >> DIGIT;
      if (w_last) r_p <= r_sign ? -w_acc_nxt : w_acc_nxt;
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: five configurations driven in lockstep, checked against a signed/unsigned reference product.
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        is_signed;
  logic        out_ready;
  logic [15:0] a16, b16;
  logic [31:0] a32, b32;
  logic [4:0]  rdy, vld;
  logic [31:0] p16 [4];
  logic [63:0] p32;

  always #5 clk = ~clk;

  // Instances 0..3: WIDTH 16 with DIGIT 8, 4, 1, 16. Instance 4: WIDTH 32, DIGIT 8.
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int D = (g == 0) ? 8 : (g == 1) ? 4 : (g == 2) ? 1 : 16;
    mult_seq #(.WIDTH(16), .DIGIT(D)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[g]),
      .is_signed(is_signed), .A(a16), .B(b16),
      .out_valid(vld[g]), .out_ready(out_ready), .P(p16[g])
    );
  end

  mult_seq #(.WIDTH(32), .DIGIT(8)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[4]),
    .is_signed(is_signed), .A(a32), .B(b32),
    .out_valid(vld[4]), .out_ready(out_ready), .P(p32)
  );

  typedef struct { logic [31:0] e16; logic [63:0] e32; } exp_t;
  typedef struct { logic [15:0] a; logic [15:0] b; logic s; logic [31:0] p; } vec_t;

  exp_t exp_q [$];
  vec_t vt [11];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 1'b0;
  bit   stall_en = 1'b0;
  int   acc_cyc [5];
  bit   seen [5];
  bit   got [5];

  function automatic int nlat(input int i);
    case (i)
      0: return 2;
      1: return 4;
      2: return 16;
      3: return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [63:0] x, y, z;
    x = s ? {{48{a[15]}}, a} : {48'd0, a};
    y = s ? {{48{b[15]}}, b} : {48'd0, b};
    z = x * y;
    return z[31:0];
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [127:0] x, y, z;
    x = s ? {{96{a[31]}}, a} : {96'd0, a};
    y = s ? {{96{b[31]}}, b} : {96'd0, b};
    z = x * y;
    return z[63:0];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (stall_en) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Scoreboard monitor: latency from accept to first out_valid, value at each output handshake.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      for (int i = 0; i < 5; i++) begin
        if (in_valid && rdy[i]) begin
          acc_cyc[i] = cyc + 1;
          seen[i]    = 1'b0;
        end
        if (vld[i] && !seen[i]) begin
          seen[i] = 1'b1;
          chk($sformatf("latency[%0d]", i), 64'(cyc - acc_cyc[i]), 64'(nlat(i)));
        end
        if (vld[i] && out_ready && !got[i]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_out[%0d]", i), 64'd1, 64'd0);
          end else if (i < 4) begin
            chk($sformatf("p16[%0d]", i), 64'(p16[i]), 64'(exp_q[0].e16));
          end else begin
            chk("p32", p32, exp_q[0].e32);
          end
          got[i] = 1'b1;
        end
      end
      if (got[0] && got[1] && got[2] && got[3] && got[4] && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) got[i] = 1'b0;
      end
    end
  end

  task automatic wait_all_rdy();
    int t = 0;
    while (rdy != 5'h1f && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (rdy != 5'h1f) chk("wait_in_ready_timeout", 64'(rdy), 64'h1f);
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [31:0] e16, input logic [31:0] aw, input logic [31:0] bw);
    exp_t e;
    wait_all_rdy();
    a16 = a; b16 = b; a32 = aw; b32 = bw; is_signed = s;
    in_valid = 1'b1;
    e.e16 = e16;
    e.e32 = ref32(aw, bw, s);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    a16       = 16'($urandom);
    b16       = 16'($urandom);
    a32       = $urandom;
    b32       = $urandom;
    is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_mon();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      got[i]  = 1'b0;
      seen[i] = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b1; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b1;
    a16 = '0; b16 = '0; a32 = '0; b32 = '0;
    reset_mon();

    vt[0]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vt[1]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vt[2]  = '{16'hFFFF, 16'h0003, 1'b1, 32'hFFFFFFFD};
    vt[3]  = '{16'h0000, 16'h1234, 1'b1, 32'h00000000};
    vt[4]  = '{16'h0000, 16'h8000, 1'b1, 32'h00000000};
    vt[5]  = '{16'h7FFF, 16'h8000, 1'b1, 32'hC0008000};
    vt[6]  = '{16'h1234, 16'h5678, 1'b0, 32'h06260060};
    vt[7]  = '{16'hFFFE, 16'hFFFD, 1'b1, 32'h00000006};
    vt[8]  = '{16'h8000, 16'hFFFF, 1'b0, 32'h7FFF8000};
    vt[9]  = '{16'hFFFF, 16'h8000, 1'b1, 32'h00008000};
    vt[10] = '{16'h0003, 16'h0000, 1'b0, 32'h00000000};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 64'(rdy), 64'h1f);
    chk("reset_out_valid", 64'(vld), 64'h0);
    for (int i = 0; i < 4; i++) chk($sformatf("reset_p16[%0d]", i), 64'(p16[i]), 64'h0);
    chk("reset_p32", p32, 64'h0);
    rst = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start_op(vt[i].a, vt[i].b, vt[i].s, vt[i].p,
               vt[i].s ? {{16{vt[i].a[15]}}, vt[i].a} : {16'h0, vt[i].a},
               vt[i].s ? {{16{vt[i].b[15]}}, vt[i].b} : {16'h0, vt[i].b});
      drain();
    end

    // Stall in DONE while in_valid stays high with changing operands.
    out_ready = 1'b0;
    start_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, 32'h00001234, 32'h00005678);
    in_valid = 1'b1;
    for (int t = 0; t < 40 && vld != 5'h1f; t++) begin
      @(posedge clk); #1;
      a16 = 16'($urandom); b16 = 16'($urandom); is_signed = 1'($urandom);
      a32 = $urandom; b32 = $urandom;
    end
    chk("done_reached", 64'(vld), 64'h1f);
    for (int t = 0; t < 5; t++) begin
      @(posedge clk); #1;
      a16 = 16'($urandom); b16 = 16'($urandom);
      chk("hold_p16_0", 64'(p16[0]), 64'h06260060);
      chk("hold_p16_2", 64'(p16[2]), 64'h06260060);
      chk("hold_in_ready", 64'(rdy), 64'h0);
      chk("hold_out_valid", 64'(vld), 64'h1f);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 64'(rdy), 64'h1f);
    chk("release_out_valid", 64'(vld), 64'h0);
    chk("release_p_kept", 64'(p16[1]), 64'h06260060);
    drain();

    // Reset in the middle of CALC (DIGIT=4 instance at k=1).
    mon_en = 1'b0;
    start_op(16'hABCD, 16'h1357, 1'b0, ref16(16'hABCD, 16'h1357, 1'b0), 32'h0000ABCD, 32'h00001357);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midreset_in_ready", 64'(rdy), 64'h1f);
    chk("midreset_out_valid", 64'(vld), 64'h0);
    chk("midreset_p16_1", 64'(p16[1]), 64'h0);
    chk("midreset_p16_3", 64'(p16[3]), 64'h0);
    chk("midreset_p32", p32, 64'h0);
    reset_mon();
    mon_en = 1'b1;
    start_op(16'hFF00, 16'h0101, 1'b1, ref16(16'hFF00, 16'h0101, 1'b1), 32'hFFFFFF00, 32'h00000101);
    drain();

    // Random operands, modes and output stalls.
    stall_en = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom);
      if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'h0000;
      if ($urandom_range(0, 7) == 0) rb = ($urandom_range(0, 1) == 0) ? 16'h8000 : 16'hFFFF;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      start_op(ra, rb, rs, ref16(ra, rb, rs), $urandom, $urandom);
    end
    drain();
    stall_en  = 1'b0;
    out_ready = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
